// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response handshake between fetch and imem
interface fetch_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  modport master (output req_valid, req_addr, input req_ready, resp_valid, resp_data);
  modport slave  (input req_valid, req_addr, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I IF stage, single-outstanding imem fetch, stall skid, redirect drain (IF_MISALIGN_TRAP_EN traps misaligned targets)
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_stage_if.master   imem,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_instruction,
  output logic            fetch_misaligned
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_t;
  state_t      state;
  logic [31:0] pc, req_pc, buf_pc, buf_data, target;
  logic        buf_valid, bad, halt, hs, take;
`ifdef IF_MISALIGN_TRAP_EN
  assign target = redirect_pc;
  assign bad    = |redirect_pc[1:0];
  assign halt   = fetch_misaligned;
`else
  assign target = redirect_pc & ~32'h3;
  assign bad    = 1'b0;
  assign halt   = 1'b0;
`endif
  assign imem.req_valid = !reset && state == FETCH && !stall && !buf_valid && !halt;
  assign imem.req_addr  = pc;
  assign hs   = imem.req_valid && imem.req_ready;
  assign take = state == WAIT && imem.resp_valid;
  // pc/fsm, IF/ID register and skid buffer; redirect outranks stall and discards any same-cycle response
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= FETCH;
      pc                <= RESET_PC;
      req_pc            <= RESET_PC;
      if_id_valid       <= 1'b0;
      if_id_pc          <= '0;
      if_id_instruction <= NOP;
      buf_valid         <= 1'b0;
      buf_pc            <= '0;
      buf_data          <= NOP;
      fetch_misaligned  <= 1'b0;
    end else if (redirect_valid) begin
      if_id_valid <= 1'b0;
      buf_valid   <= 1'b0;
      if (bad) fetch_misaligned <= 1'b1;
      else pc <= target;
      state <= (hs || (state != FETCH && !imem.resp_valid)) ? DRAIN : FETCH;
    end else begin
      case (state)
        FETCH: if (hs) begin
          req_pc <= pc;
          pc     <= pc + 32'd4;
          state  <= WAIT;
        end
        WAIT, DRAIN: if (imem.resp_valid) state <= FETCH;
        default: state <= FETCH;
      endcase
      if (!stall) begin
        if (buf_valid) begin
          if_id_valid       <= 1'b1;
          if_id_pc          <= buf_pc;
          if_id_instruction <= buf_data;
          buf_valid         <= 1'b0;
        end else if (take) begin
          if_id_valid       <= 1'b1;
          if_id_pc          <= req_pc;
          if_id_instruction <= imem.resp_data;
        end else
          if_id_valid <= 1'b0;
      end else if (take) begin
        if (!if_id_valid) begin
          if_id_valid       <= 1'b1;
          if_id_pc          <= req_pc;
          if_id_instruction <= imem.resp_data;
        end else begin
          buf_valid <= 1'b1;
          buf_pc    <= req_pc;
          buf_data  <= imem.resp_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against a latency-programmable instruction memory
module tb_fetch_stage;
  logic        clock = 1'b0;
  logic        reset, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid, fetch_misaligned;
  logic [31:0] if_id_pc, if_id_instruction;
  int          n_tests = 0, n_fail = 0;
  int          lat, cnt;
  logic        pend = 1'b0;
  logic [31:0] paddr;
  fetch_stage_if imem ();
  fetch_stage dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem(imem), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
    .if_id_instruction(if_id_instruction), .fetch_misaligned(fetch_misaligned)
  );
  always #5 clock = ~clock;
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction
  // memory: answers each accepted request lat cycles after the accepting edge (lat=0: next cycle)
  always @(posedge clock) begin
    imem.resp_valid <= 1'b0;
    if (reset) pend <= 1'b0;
    else if (pend) begin
      if (cnt == 0) begin
        imem.resp_valid <= 1'b1;
        imem.resp_data  <= word(paddr);
        pend            <= 1'b0;
      end else cnt <= cnt - 1;
    end else if (imem.req_valid && imem.req_ready) begin
      if (lat == 0) begin
        imem.resp_valid <= 1'b1;
        imem.resp_data  <= word(imem.req_addr);
      end else begin
        pend  <= 1'b1;
        paddr <= imem.req_addr;
        cnt   <= lat - 1;
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #2;
  endtask
  initial begin
    reset = 1; stall = 0; redirect_valid = 0; redirect_pc = 0; imem.req_ready = 1; lat = 0;
    step(); step(); #1;
    check("rst_req_valid", imem.req_valid, 0);
    check("rst_if_id_valid", if_id_valid, 0);
    check("rst_if_id_pc", if_id_pc, 0);
    check("rst_if_id_instr", if_id_instruction, 32'h13);
    check("rst_misaligned", fetch_misaligned, 0);
    reset = 0; #1;
    check("req0_valid", imem.req_valid, 1);
    check("req0_addr", imem.req_addr, 0);
    step(); #1;
    check("wait_if_id_valid", if_id_valid, 0);
    check("wait_req_valid", imem.req_valid, 0);
    step(); #1;
    check("i0_valid", if_id_valid, 1);
    check("i0_pc", if_id_pc, 0);
    check("i0_instr", if_id_instruction, word(0));
    check("req4_addr", imem.req_addr, 4);
    step(); step(); #1;
    check("i4_pc", if_id_pc, 4);
    check("req8_addr", imem.req_addr, 8);
    stall = 1; #1;
    check("stall_no_req", imem.req_valid, 0);
    step(); #1;
    check("stall_hold_valid", if_id_valid, 1);
    check("stall_hold_pc", if_id_pc, 4);
    stall = 0;
    step();
    stall = 1;
    step(); #1;
    check("i8_valid", if_id_valid, 1);
    check("i8_pc", if_id_pc, 8);
    check("i8_instr", if_id_instruction, word(8));
    step(); step(); #1;
    check("stall3_pc", if_id_pc, 8);
    check("stall3_valid", if_id_valid, 1);
    check("stall3_no_req", imem.req_valid, 0);
    stall = 0; #1;
    check("reqC_valid", imem.req_valid, 1);
    check("reqC_addr", imem.req_addr, 32'hC);
    lat = 1;
    step();
    redirect_valid = 1; redirect_pc = 32'h100;
    step();
    redirect_valid = 0; #1;
    check("drain_if_id_valid", if_id_valid, 0);
    check("drain_no_req", imem.req_valid, 0);
    step(); #1;
    check("drained_discard", if_id_valid, 0);
    check("req100_valid", imem.req_valid, 1);
    check("req100_addr", imem.req_addr, 32'h100);
    lat = 0;
    step(); step(); #1;
    check("i100_pc", if_id_pc, 32'h100);
    check("i100_instr", if_id_instruction, word(32'h100));
    imem.req_ready = 0; #1;
    check("req104_addr", imem.req_addr, 32'h104);
    step(); step();
    redirect_valid = 1; redirect_pc = 32'h40;
    step();
    redirect_valid = 0; #1;
    check("req40_addr", imem.req_addr, 32'h40);
    check("req40_no_drain", imem.req_valid, 1);
    step(); #1;
    check("req40_held", imem.req_addr, 32'h40);
    imem.req_ready = 1;
    step(); step(); #1;
    check("i40_pc", if_id_pc, 32'h40);
    stall = 1; redirect_valid = 1; redirect_pc = 32'h200;
    step();
    stall = 0; redirect_valid = 0; #1;
    check("redir_stall_flush", if_id_valid, 0);
    check("req200_addr", imem.req_addr, 32'h200);
    stall = 1; redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    step();
    stall = 0; redirect_valid = 0; #1;
    check("reqtop_addr", imem.req_addr, 32'hFFFF_FFFC);
    step(); step(); #1;
    check("itop_pc", if_id_pc, 32'hFFFF_FFFC);
    check("itop_instr", if_id_instruction, word(32'hFFFF_FFFC));
    check("wrap_addr", imem.req_addr, 0);
    stall = 1; redirect_valid = 1; redirect_pc = 32'h102;
    step();
    stall = 0; redirect_valid = 0; #1;
`ifdef IF_MISALIGN_TRAP_EN
    check("mis_flag", fetch_misaligned, 1);
    check("mis_halt", imem.req_valid, 0);
    lat = 1;
    step(); #1;
    check("mis_sticky", fetch_misaligned, 1);
    check("mis_halt2", imem.req_valid, 0);
`else
    check("mis_flag_off", fetch_misaligned, 0);
    check("align_addr", imem.req_addr, 32'h100);
    lat = 1;
    step(); #1;
    check("align_wait", imem.req_valid, 0);
`endif
    reset = 1; lat = 0;
    step();
    reset = 0; #1;
    check("rst2_req_valid", imem.req_valid, 1);
    check("rst2_req_addr", imem.req_addr, 0);
    check("rst2_if_id_valid", if_id_valid, 0);
    check("rst2_instr", if_id_instruction, 32'h13);
    check("rst2_misaligned", fetch_misaligned, 0);
    step(); #1;
    check("rst2_ignore_old", if_id_valid, 0);
    step(); #1;
    check("rst2_i0_pc", if_id_pc, 0);
    check("rst2_i0_instr", if_id_instruction, word(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
